muldiv_iter: RTL

- Parametrised iterative multiply/divide unit for the execute stage. It supersedes the divide-only unit and removes the combinational multiply from the ALU.
- Performs signed and unsigned multiply and divide, one bit per cycle, using a start/busy/ready handshake and an annul input.
- Its 2×WIDTH result feeds the hi/lo mux ahead of the M pipeline register.
- The hazard unit stalls E while busy_o is high.

---
 rtl/muldiv_iter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and divide unit, one result bit per cycle.
// busy_o/ready_o are registered one cycle behind the state that produces them.

module muldiv_iter #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] DIVZERO_LO = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  logic               op_signed, op_div;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // The W+1-bit partial remainder lives only in div_shift/div_diff; the stored
  // remainder is always below the divisor, so W bits hold it between cycles.
  always_comb begin
    op_signed = ~op_i[0];
    op_div    = op_i[1];
    abs1      = (op_signed && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs2      = (op_signed && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quot_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    result_d  = result_q;
    busy_d    = (state_q == CALC || state_q == FIX) && !annul_i;
    ready_d   = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (op_div && opdata2_i == '0) begin
            result_d = {opdata1_i, DIVZERO_LO};
            state_d  = DONE;
          end else begin
            is_div_d  = op_div;
            neg_res_d = op_signed && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_d = op_signed && opdata1_i[WIDTH-1];
            mcand_d   = op_div ? abs2 : abs1;
            acc_d     = {{WIDTH{1'b0}}, (op_div ? abs1 : abs2)};
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          // Divide shifts the dividend out of acc's low half while quotient bits shift in.
          if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
              rem_d = div_diff[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = div_shift[WIDTH-1:0];
              acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = FIX;
        end
      end
      FIX: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          result_d = is_div_q ? {rem_fix, quot_fix} : prod_fix;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign busy_o   = busy_q;
  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule
